// File: rtl/fifo_drain_scheduler.sv
// Round-robin drain of two FIFO pop ports onto one valid/ready stream; pop-to-valid is 2 cycles.
// A pop is only issued when the output register is empty or emptying, so a stalled sink halts popping.
module fifo_drain_scheduler #(
   parameter int BURST_LEN = 8,
   parameter int DATAWIDTH = 16
) (
   input  logic                 WBs_CLK_i,
   input  logic                 WBs_RSTn_i,
   input  logic                 Enable_i,
   input  logic [3:0]           Ch0_POP_FLAG_i,
   input  logic [7:0]           Ch0_DOUT_i,
   output logic                 Ch0_POP_o,
   input  logic [3:0]           Ch1_POP_FLAG_i,
   input  logic [15:0]          Ch1_DOUT_i,
   output logic                 Ch1_POP_o,
   output logic [DATAWIDTH-1:0] Str_DAT_o,
   output logic                 Str_SRC_o,
   output logic                 Str_LAST_o,
   output logic                 Str_VLD_o,
   input  logic                 Str_RDY_i,
   output logic                 Busy_o
);

   typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPT, S_HOLD} state_t;

   state_t                 r_state;
   logic                   r_gnt;
   logic                   r_last_gnt;
   logic [3:0]             r_cnt;
   logic                   r_last_pend;
   logic [DATAWIDTH-1:0]   r_dat;
   logic                   r_src;
   logic                   r_lst;
   logic                   r_vld;

   logic                   w_req0;
   logic                   w_req1;
   logic                   w_arb;
   logic [3:0]             w_flag;
   logic                   w_slot_free;
   logic                   w_xfer;
   logic                   w_pop;
   logic [DATAWIDTH-1:0]   w_dout;

   assign w_req0      = (Ch0_POP_FLAG_i != 4'h0);
   assign w_req1      = (Ch1_POP_FLAG_i != 4'h0);
   // With both channels requesting, the one not served last time wins.
   assign w_arb       = (w_req0 && w_req1) ? ~r_last_gnt : w_req1;
   assign w_flag      = r_gnt ? Ch1_POP_FLAG_i : Ch0_POP_FLAG_i;
   assign w_xfer      = r_vld & Str_RDY_i;
   assign w_slot_free = ~r_vld | Str_RDY_i;
   assign w_dout      = r_gnt ? DATAWIDTH'(Ch1_DOUT_i) : DATAWIDTH'(Ch0_DOUT_i);

   // The pop decision depends on this cycle's ready, so the pulse is decoded rather than registered.
   assign w_pop = WBs_RSTn_i && (r_state == S_POP) && (w_flag != 4'h0) && w_slot_free;

   assign Ch0_POP_o  = w_pop & ~r_gnt;
   assign Ch1_POP_o  = w_pop &  r_gnt;
   assign Str_DAT_o  = r_dat;
   assign Str_SRC_o  = r_src;
   assign Str_LAST_o = r_lst;
   assign Str_VLD_o  = r_vld;
   assign Busy_o     = (r_state != S_IDLE) | r_vld;

   always_ff @(posedge WBs_CLK_i) begin
      if (!WBs_RSTn_i) begin
         r_state     <= S_IDLE;
         r_gnt       <= 1'b0;
         r_last_gnt  <= 1'b1;
         r_cnt       <= 4'd0;
         r_last_pend <= 1'b0;
         r_dat       <= '0;
         r_src       <= 1'b0;
         r_lst       <= 1'b0;
         r_vld       <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_vld <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (Enable_i && (w_req0 || w_req1)) begin
                  r_gnt      <= w_arb;
                  r_last_gnt <= w_arb;
                  r_cnt      <= 4'd0;
                  r_state    <= S_POP;
               end
            end
            S_POP: begin
               if (w_flag == 4'h0) begin
                  r_state <= S_IDLE;
               end else if (w_slot_free) begin
                  r_last_pend <= (w_flag == 4'h1) || (r_cnt == 4'(BURST_LEN - 1));
                  r_state     <= S_CAPT;
               end
            end
            S_CAPT: begin
               // The slot was freed when the pop was issued, so the load never clobbers a word.
               r_dat   <= w_dout;
               r_src   <= r_gnt;
               r_lst   <= r_last_pend;
               r_vld   <= 1'b1;
               r_cnt   <= r_cnt + 4'd1;
               r_state <= r_last_pend ? S_HOLD : S_POP;
            end
            S_HOLD: begin
               if (w_xfer) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Bench for fifo_drain_scheduler: FIFO models on both pop ports, a queue-based burst model feeding a scoreboard,
// and a monitor that checks transfers, pop rules, latency and hold stability.
module tb_fifo_drain_scheduler;
   localparam int BL = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Enable_i;
   logic [3:0]  Ch0_POP_FLAG_i, Ch1_POP_FLAG_i;
   logic [7:0]  Ch0_DOUT_i;
   logic [15:0] Ch1_DOUT_i;
   logic        Ch0_POP_o, Ch1_POP_o;
   logic [15:0] Str_DAT_o;
   logic        Str_SRC_o, Str_LAST_o, Str_VLD_o, Str_RDY_i, Busy_o;

   always #5 clk = ~clk;

   fifo_drain_scheduler #(.BURST_LEN(BL), .DATAWIDTH(16)) dut (
      .WBs_CLK_i(clk), .WBs_RSTn_i(rst_n), .Enable_i(Enable_i),
      .Ch0_POP_FLAG_i(Ch0_POP_FLAG_i), .Ch0_DOUT_i(Ch0_DOUT_i), .Ch0_POP_o(Ch0_POP_o),
      .Ch1_POP_FLAG_i(Ch1_POP_FLAG_i), .Ch1_DOUT_i(Ch1_DOUT_i), .Ch1_POP_o(Ch1_POP_o),
      .Str_DAT_o(Str_DAT_o), .Str_SRC_o(Str_SRC_o), .Str_LAST_o(Str_LAST_o),
      .Str_VLD_o(Str_VLD_o), .Str_RDY_i(Str_RDY_i), .Busy_o(Busy_o)
   );

   typedef struct packed {logic [15:0] d; logic s; logic l;} exp_t;

   exp_t        sb[$];
   logic [7:0]  q0[$];
   logic [15:0] q1[$];
   int          popq[$];
   int          n_chk = 0, n_pass = 0;
   int          cyc = 0, pop_cnt = 0, rdy_mode = 0;
   bit          m_last = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic [3:0] flag_of(input int n);
      return (n > 15) ? 4'hf : 4'(n);
   endfunction

   task automatic upd_flags();
      Ch0_POP_FLAG_i = flag_of(q0.size());
      Ch1_POP_FLAG_i = flag_of(q1.size());
   endtask

   task automatic load(input int n0, input int n1);
      @(posedge clk); #2;
      for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) q1.push_back(16'($urandom));
      upd_flags();
   endtask

   // Reference: replay the FIFO contents as a sequence of bursts (alternate while both
   // are non-empty, up to BL words each, LAST on the final word) into the scoreboard.
   task automatic build_expect();
      int   r0, r1, i0, i1, n;
      bit   g;
      exp_t e;
      i0 = 0; i1 = 0;
      r0 = q0.size(); r1 = q1.size();
      while (r0 > 0 || r1 > 0) begin
         g = (r0 > 0 && r1 > 0) ? !m_last : (r1 > 0);
         m_last = g;
         n = g ? r1 : r0;
         if (n > BL) n = BL;
         for (int k = 0; k < n; k++) begin
            e.d = g ? q1[i1 + k] : {8'h00, q0[i0 + k]};
            e.s = g;
            e.l = (k == n - 1);
            sb.push_back(e);
         end
         if (g) begin i1 += n; r1 -= n; end
         else   begin i0 += n; r0 -= n; end
      end
   endtask

   task automatic wait_drain(input string nm);
      int k = 0;
      while ((sb.size() != 0 || Busy_o) && k < 3000) begin
         @(negedge clk); k++;
      end
      chk({nm, "_drained"}, {31'd0, (sb.size() == 0 && !Busy_o)}, 32'd1);
      sb.delete();
      repeat (3) @(negedge clk);
   endtask

   // FIFO models: pop seen in cycle t, data and flags updated early in cycle t+1.
   bit          f_p0, f_p1;
   logic [7:0]  f_d0;
   logic [15:0] f_d1;
   initial begin
      forever begin
         @(negedge clk);
         f_p0 = Ch0_POP_o; f_p1 = Ch1_POP_o;
         if (f_p0) begin
            chk("pop0_nonempty", {31'd0, q0.size() != 0}, 32'd1);
            f_d0 = (q0.size() != 0) ? q0.pop_front() : 8'hxx;
         end
         if (f_p1) begin
            chk("pop1_nonempty", {31'd0, q1.size() != 0}, 32'd1);
            f_d1 = (q1.size() != 0) ? q1.pop_front() : 16'hxxxx;
         end
         @(posedge clk); #1;
         Ch0_DOUT_i = f_p0 ? f_d0 : 8'($urandom);
         Ch1_DOUT_i = f_p1 ? f_d1 : 16'($urandom);
         upd_flags();
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       Str_RDY_i = 1'b1;
            1:       Str_RDY_i = ($urandom_range(0, 2) != 0);
            default: Str_RDY_i = 1'b0;
         endcase
      end
   end

   bit          pv_vld, pv_xfer, pv_pop;
   logic [17:0] pv_word;
   exp_t        mon_e;
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            pv_vld = 0; pv_xfer = 0; pv_pop = 0;
         end else begin
            if (Ch0_POP_o || Ch1_POP_o) begin
               chk("pop_exclusive", {31'd0, Ch0_POP_o & Ch1_POP_o}, 32'd0);
               chk("pop_back_to_back", {31'd0, pv_pop}, 32'd0);
               chk("pop_while_occupied", {31'd0, Str_VLD_o & ~Str_RDY_i}, 32'd0);
               popq.push_back(cyc);
               pop_cnt++;
            end
            if (Str_VLD_o && (!pv_vld || pv_xfer)) begin
               if (popq.size() != 0) chk("pop_to_valid_latency", 32'(cyc - popq.pop_front()), 32'd2);
               else chk("word_without_pop", 32'd1, 32'd0);
            end
            if (Str_VLD_o && pv_vld && !pv_xfer)
               chk("hold_stable", {14'd0, Str_DAT_o, Str_SRC_o, Str_LAST_o}, {14'd0, pv_word});
            if (Str_VLD_o) chk("busy_with_valid", {31'd0, Busy_o}, 32'd1);
            if (Str_VLD_o && Str_RDY_i) begin
               if (sb.size() != 0) begin
                  mon_e = sb.pop_front();
                  chk("stream_word", {14'd0, Str_DAT_o, Str_SRC_o, Str_LAST_o}, {14'd0, mon_e});
               end else begin
                  chk("unexpected_word", {14'd0, Str_DAT_o, Str_SRC_o, Str_LAST_o}, 32'hdead_beef);
               end
            end
            pv_vld  = Str_VLD_o;
            pv_xfer = Str_VLD_o & Str_RDY_i;
            pv_pop  = Ch0_POP_o | Ch1_POP_o;
            pv_word = {Str_DAT_o, Str_SRC_o, Str_LAST_o};
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ctl"}, {26'd0, Str_VLD_o, Str_SRC_o, Str_LAST_o, Busy_o, Ch0_POP_o, Ch1_POP_o}, 32'd0);
      chk({nm, "_dat"}, {16'd0, Str_DAT_o}, 32'd0);
   endtask

   initial begin
      int k, base, saved;
      rst_n = 1'b0; Enable_i = 1'b0; Str_RDY_i = 1'b1;
      Ch0_DOUT_i = 8'h00; Ch1_DOUT_i = 16'h0000;
      upd_flags();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // single ch0 word
      load(1, 0);
      build_expect();
      Enable_i = 1'b1;
      wait_drain("single");
      chk("single_idle_busy", {31'd0, Busy_o}, 32'd0);

      // long alternating bursts with a 10-cycle sink stall mid-burst
      load(20, 20);
      build_expect();
      repeat (40) @(posedge clk);
      rdy_mode = 2;
      repeat (10) @(posedge clk);
      rdy_mode = 0;
      wait_drain("alternate");

      // enable dropped after the 2nd pop of a 5-word ch0 burst
      load(5, 0);
      build_expect();
      base = pop_cnt; k = 0;
      while (pop_cnt < base + 2 && k < 100) begin @(negedge clk); k++; end
      chk("en_drop_two_pops", {31'd0, pop_cnt >= base + 2}, 32'd1);
      @(posedge clk); #1 Enable_i = 1'b0;
      load(0, 3);
      wait_drain("en_drop");
      saved = pop_cnt;
      repeat (20) @(negedge clk);
      chk("en_drop_no_grant", 32'(pop_cnt), 32'(saved));
      chk("en_drop_idle", {31'd0, Busy_o}, 32'd0);

      // ch1 holds 3 words and last grant was ch0: ch1 burst of 3, then ch0
      load(2, 0);
      build_expect();
      @(posedge clk); #1 Enable_i = 1'b1;
      wait_drain("ch1_three");

      // reset in the cycle after a pop: in-flight word dropped, ch0 first after release
      @(posedge clk); #1 Enable_i = 1'b0;
      load(4, 2);
      @(posedge clk); #1 Enable_i = 1'b1;
      k = 0;
      while (!(Ch0_POP_o || Ch1_POP_o) && k < 50) begin @(negedge clk); k++; end
      chk("rst_pop_seen", {31'd0, Ch0_POP_o | Ch1_POP_o}, 32'd1);
      @(posedge clk); #1 rst_n = 1'b0; Enable_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("mid_reset");
      @(posedge clk); #1 rst_n = 1'b1;
      sb.delete(); popq.delete();
      m_last = 1'b1;
      build_expect();
      Enable_i = 1'b1;
      wait_drain("after_reset");

      // randomized fills with a randomly stalling sink
      for (int it = 0; it < 8; it++) begin
         rdy_mode = (it == 0) ? 0 : 1;
         load($urandom_range(0, 20), $urandom_range(0, 20));
         build_expect();
         wait_drain("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
